// File: rtl/axi4_stream_arb_pkg.sv
// Shared types and helpers for the AXI4-Stream packet arbiter and its round-robin picker.
package axi4_stream_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Next channel index with an explicit wrap, so non power-of-two counts never overflow.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle; master drives payload and tvalid, slave drives tready.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);
  localparam int TSTRB_WIDTH = TDATA_WIDTH / 8;

  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TSTRB_WIDTH-1:0] tstrb;
  logic [TSTRB_WIDTH-1:0] tkeep;
  logic                   tlast;
  logic [TUSER_WIDTH-1:0] tuser;
  logic [TDEST_WIDTH-1:0] tdest;
  logic [TID_WIDTH-1:0]   tid;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
    output tready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', wrapping at CH_AMOUNT-1.
module rr_arbiter
  import axi4_stream_arb_pkg::*;
#(
  parameter int CH_AMOUNT = 4,
  parameter int CH_WIDTH  = $clog2(CH_AMOUNT)
) (
  input  logic [CH_AMOUNT-1:0] req,
  input  logic [CH_WIDTH-1:0]  last,
  output logic [CH_WIDTH-1:0]  gnt_idx,
  output logic                 gnt_valid
);

  logic [CH_WIDTH-1:0] scan_idx;

  always_comb begin
    gnt_idx   = last;
    gnt_valid = 1'b0;
    scan_idx  = last;
    for (int i = 0; i < CH_AMOUNT; i++) begin
      scan_idx = CH_WIDTH'(rr_next(int'(scan_idx), CH_AMOUNT));
      if (!gnt_valid && req[scan_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

endmodule

// File: rtl/axi4_stream_pkt_arbiter.sv
// Packet-level round-robin scheduler: shares one registered AXI4-Stream output between
// CH_AMOUNT packet FIFOs, holding each grant from the first word through tlast.
module axi4_stream_pkt_arbiter
  import axi4_stream_arb_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter int CH_AMOUNT   = 4,
  parameter int ADDR_WIDTH  = 3,
  parameter int CH_WIDTH    = $clog2(CH_AMOUNT)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [CH_AMOUNT*(ADDR_WIDTH+1)-1:0] pkts_amount_i,
  axi4_stream_if.slave                      pkt_i [CH_AMOUNT],
  axi4_stream_if.master                     pkt_o,
  output logic [CH_AMOUNT-1:0]              grant_o,
  output logic [CH_WIDTH-1:0]               cur_ch_o,
  output logic                              busy_o
);

  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int STRB_W = TDATA_WIDTH / 8;

  arb_state_t          state_q, state_d;
  logic [CH_WIDTH-1:0] cur_ch_q, cur_ch_d;

  logic [CH_AMOUNT-1:0]   elig;
  logic [CH_AMOUNT-1:0]   in_valid;
  logic [CH_AMOUNT-1:0]   in_last;
  logic [TDATA_WIDTH-1:0] in_data [CH_AMOUNT];
  logic [STRB_W-1:0]      in_strb [CH_AMOUNT];
  logic [STRB_W-1:0]      in_keep [CH_AMOUNT];
  logic [TUSER_WIDTH-1:0] in_user [CH_AMOUNT];
  logic [TDEST_WIDTH-1:0] in_dest [CH_AMOUNT];
  logic [TID_WIDTH-1:0]   in_id   [CH_AMOUNT];

  logic                   out_valid_q;
  logic [TDATA_WIDTH-1:0] out_data_q;
  logic [STRB_W-1:0]      out_strb_q;
  logic [STRB_W-1:0]      out_keep_q;
  logic                   out_last_q;
  logic [TUSER_WIDTH-1:0] out_user_q;
  logic [TDEST_WIDTH-1:0] out_dest_q;
  logic [TID_WIDTH-1:0]   out_id_q;

  logic                busy;
  logic                out_free;
  logic                accept;
  logic [CH_WIDTH-1:0] rr_idx;
  logic                rr_valid;

  assign busy     = (state_q == XFER);
  assign out_free = !out_valid_q || pkt_o.tready;
  assign accept   = busy && in_valid[cur_ch_q] && out_free;

  // Flatten the interface array so the granted channel can be selected by a runtime index.
  for (genvar gi = 0; gi < CH_AMOUNT; gi++) begin : g_ch
    assign elig[gi]     = |pkts_amount_i[gi*CNT_W +: CNT_W];
    assign in_valid[gi] = pkt_i[gi].tvalid;
    assign in_last[gi]  = pkt_i[gi].tlast;
    assign in_data[gi]  = pkt_i[gi].tdata;
    assign in_strb[gi]  = pkt_i[gi].tstrb;
    assign in_keep[gi]  = pkt_i[gi].tkeep;
    assign in_user[gi]  = pkt_i[gi].tuser;
    assign in_dest[gi]  = pkt_i[gi].tdest;
    assign in_id[gi]    = pkt_i[gi].tid;

    assign grant_o[gi]      = busy && (cur_ch_q == CH_WIDTH'(gi));
    assign pkt_i[gi].tready = busy && (cur_ch_q == CH_WIDTH'(gi)) && out_free;
  end

  // In IDLE cur_ch_q still names the last granted channel, so it doubles as the RR pointer.
  rr_arbiter #(
    .CH_AMOUNT (CH_AMOUNT),
    .CH_WIDTH  (CH_WIDTH)
  ) u_rr (
    .req       (elig),
    .last      (cur_ch_q),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    case (state_q)
      IDLE: begin
        if (rr_valid) begin
          state_d  = XFER;
          cur_ch_d = rr_idx;
        end
      end
      XFER: begin
        if (accept && in_last[cur_ch_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cur_ch_q <= CH_WIDTH'(CH_AMOUNT - 1);
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_user_q  <= '0;
      out_dest_q  <= '0;
      out_id_q    <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= in_data[cur_ch_q];
      out_strb_q  <= in_strb[cur_ch_q];
      out_keep_q  <= in_keep[cur_ch_q];
      out_last_q  <= in_last[cur_ch_q];
      out_user_q  <= in_user[cur_ch_q];
      out_dest_q  <= in_dest[cur_ch_q];
      out_id_q    <= in_id[cur_ch_q];
    end else if (pkt_o.tready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign pkt_o.tvalid = out_valid_q;
  assign pkt_o.tdata  = out_data_q;
  assign pkt_o.tstrb  = out_strb_q;
  assign pkt_o.tkeep  = out_keep_q;
  assign pkt_o.tlast  = out_last_q;
  assign pkt_o.tuser  = out_user_q;
  assign pkt_o.tdest  = out_dest_q;
  assign pkt_o.tid    = out_id_q;

  assign cur_ch_o = cur_ch_q;
  assign busy_o   = busy;

endmodule

// File: tb/tb_axi4_stream_pkt_arbiter.sv
// Scoreboard bench for axi4_stream_pkt_arbiter: FIFO models feed packets, outputs are
// checked against words in input-acceptance order plus bench-derived grant sequences.
module tb_axi4_stream_pkt_arbiter;

  localparam int DW   = 32;
  localparam int UW   = 1;
  localparam int DSW  = 1;
  localparam int IW   = 1;
  localparam int NCH  = 4;
  localparam int AW   = 3;
  localparam int CW   = 2;
  localparam int CNTW = AW + 1;
  localparam int SW   = DW / 8;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [SW-1:0]  strb;
    logic [SW-1:0]  keep;
    logic           last;
    logic [UW-1:0]  user;
    logic [DSW-1:0] dest;
    logic [IW-1:0]  id;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi4_stream_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .TDEST_WIDTH(DSW), .TID_WIDTH(IW)) in_if [NCH] ();
  axi4_stream_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .TDEST_WIDTH(DSW), .TID_WIDTH(IW)) out_if ();

  logic [NCH*CNTW-1:0] pkts_amount;
  logic [NCH-1:0]      grant;
  logic [CW-1:0]       cur_ch;
  logic                busy;
  logic [NCH-1:0]      src_valid;
  logic [NCH-1:0]      src_ready;
  word_t               src_word [NCH];
  logic                out_ready;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_src
    assign in_if[gi].tvalid = src_valid[gi];
    assign in_if[gi].tdata  = src_word[gi].data;
    assign in_if[gi].tstrb  = src_word[gi].strb;
    assign in_if[gi].tkeep  = src_word[gi].keep;
    assign in_if[gi].tlast  = src_word[gi].last;
    assign in_if[gi].tuser  = src_word[gi].user;
    assign in_if[gi].tdest  = src_word[gi].dest;
    assign in_if[gi].tid    = src_word[gi].id;
    assign src_ready[gi]    = in_if[gi].tready;
  end
  assign out_if.tready = out_ready;

  axi4_stream_pkt_arbiter #(
    .TDATA_WIDTH (DW),
    .TUSER_WIDTH (UW),
    .TDEST_WIDTH (DSW),
    .TID_WIDTH   (IW),
    .CH_AMOUNT   (NCH),
    .ADDR_WIDTH  (AW),
    .CH_WIDTH    (CW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pkts_amount_i (pkts_amount),
    .pkt_i         (in_if),
    .pkt_o         (out_if),
    .grant_o       (grant),
    .cur_ch_o      (cur_ch),
    .busy_o        (busy)
  );

  // FIFO source models, scoreboard and logs
  word_t      mem [NCH][DEPTH];
  int         rd_ptr [NCH];
  int         wr_ptr [NCH];
  int         pkt_cnt [NCH];
  word_t      exp_q [$];
  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;
  int         glog_ch [64];
  int         glog_cyc [64];
  int         gnum;
  int         olog_cyc [64];
  int         onum;
  bit         prev_busy;
  bit         in_pkt;
  int         pkt_ch;
  int         pkt_word;
  logic [3:0] rdy_pat;

  task automatic clear_model();
    for (int c = 0; c < NCH; c++) begin
      rd_ptr[c]  = 0;
      wr_ptr[c]  = 0;
      pkt_cnt[c] = 0;
      src_valid[c] = 1'b0;
      src_word[c]  = '0;
    end
    pkts_amount = '0;
    exp_q.delete();
    gnum = 0;
    onum = 0;
    prev_busy = 1'b0;
    in_pkt = 1'b0;
    pkt_ch = 0;
    pkt_word = 0;
    rdy_pat = 4'b1111;
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic add_packet(input int ch, input int pid, input int len);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w.data = {8'(ch), 8'(pid), 16'(i)};
      w.strb = 4'(i + 1);
      w.keep = 4'hF;
      w.last = (i == len - 1);
      w.user = 1'(i);
      w.dest = 1'(ch);
      w.id   = 1'(ch >> 1);
      mem[ch][wr_ptr[ch]] = w;
      wr_ptr[ch]++;
    end
    pkt_cnt[ch]++;
  endtask

  // One clock cycle: drive sources at negedge, sample handshakes, update models at posedge.
  task automatic step();
    bit [NCH-1:0]   ihs;
    bit             ohs;
    word_t          ow;
    word_t          e;
    logic [NCH-1:0] exp_g;
    logic           exp_rdy;
    int             gidx;
    for (int c = 0; c < NCH; c++) begin
      src_valid[c] = (rd_ptr[c] != wr_ptr[c]);
      src_word[c]  = src_valid[c] ? mem[c][rd_ptr[c]] : '0;
      pkts_amount[c*CNTW +: CNTW] = CNTW'(pkt_cnt[c]);
    end
    out_ready = rdy_pat[cyc % 4];
    #1;
    exp_g = busy ? (NCH'(1) << cur_ch) : '0;
    compared++;
    if (grant !== exp_g) begin
      mismatched++;
      $display("FAIL grant_onehot cyc=%0d: got %b expected %b", cyc, grant, exp_g);
    end
    for (int c = 0; c < NCH; c++) begin
      exp_rdy = busy && (int'(cur_ch) == c) && (!out_if.tvalid || out_ready);
      compared++;
      if (src_ready[c] !== exp_rdy) begin
        mismatched++;
        $display("FAIL tready_ch%0d cyc=%0d: got %b expected %b", c, cyc, src_ready[c], exp_rdy);
      end
      ihs[c] = src_valid[c] && src_ready[c];
    end
    ohs = out_if.tvalid && out_ready;
    ow.data = out_if.tdata;
    ow.strb = out_if.tstrb;
    ow.keep = out_if.tkeep;
    ow.last = out_if.tlast;
    ow.user = out_if.tuser;
    ow.dest = out_if.tdest;
    ow.id   = out_if.tid;
    @(posedge clk);
    cyc++;
    for (int c = 0; c < NCH; c++) begin
      if (ihs[c]) begin
        exp_q.push_back(mem[c][rd_ptr[c]]);
        if (mem[c][rd_ptr[c]].last) pkt_cnt[c]--;
        rd_ptr[c]++;
      end
    end
    if (ohs) begin
      if (onum < 64) olog_cyc[onum] = cyc;
      onum++;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL out_word cyc=%0d: got %0h with nothing expected", cyc, ow);
      end else begin
        e = exp_q.pop_front();
        if (ow !== e) begin
          mismatched++;
          $display("FAIL out_word cyc=%0d: got %0h expected %0h", cyc, ow, e);
        end
      end
      compared++;
      if (in_pkt ? (int'(ow.data[31:24]) != pkt_ch || int'(ow.data[15:0]) != pkt_word)
                 : (ow.data[15:0] != 16'd0)) begin
        mismatched++;
        $display("FAIL contiguity cyc=%0d: got tdata %0h expected ch %0d word %0d",
                 cyc, ow.data, pkt_ch, in_pkt ? pkt_word : 0);
      end
      in_pkt   = !ow.last;
      pkt_ch   = int'(ow.data[31:24]);
      pkt_word = int'(ow.data[15:0]) + 1;
    end
    @(negedge clk);
    if (busy && !prev_busy && gnum < 64) begin
      gidx = -1;
      for (int c = 0; c < NCH; c++) if (grant[c]) gidx = c;
      glog_ch[gnum]  = gidx;
      glog_cyc[gnum] = cyc;
      gnum++;
    end
    prev_busy = busy;
  endtask

  function automatic bit all_empty();
    for (int c = 0; c < NCH; c++) if (rd_ptr[c] != wr_ptr[c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_drain(input int max_cyc, input string name);
    int n = 0;
    while (!(all_empty() && exp_q.size() == 0 && !out_if.tvalid && !busy) && n < max_cyc) begin
      step();
      n++;
    end
    compared++;
    if (n >= max_cyc) begin
      mismatched++;
      $display("FAIL %s_drain: got timeout after %0d cycles, required drained", name, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
    compared++;
    if (grant !== '0) begin mismatched++; $display("FAIL reset_grant: got %b expected 0", grant); end
    compared++;
    if (cur_ch !== CW'(NCH - 1)) begin mismatched++; $display("FAIL reset_cur_ch: got %0d expected %0d", cur_ch, NCH - 1); end
    compared++;
    if (out_if.tvalid !== 1'b0) begin mismatched++; $display("FAIL reset_tvalid: got %b expected 0", out_if.tvalid); end
    compared++;
    if (out_if.tdata !== '0 || out_if.tlast !== 1'b0 || out_if.tkeep !== '0) begin
      mismatched++; $display("FAIL reset_fields: got tdata %0h tlast %b tkeep %0h expected 0", out_if.tdata, out_if.tlast, out_if.tkeep);
    end
    compared++;
    if (src_ready !== '0) begin mismatched++; $display("FAIL reset_tready: got %b expected 0", src_ready); end
  endtask

  task automatic test_single_channel();
    int start;
    do_reset();
    add_packet(2, 0, 4);
    start = cyc;
    run_drain(40, "single");
    compared++;
    if (gnum !== 1 || glog_ch[0] !== 2) begin mismatched++; $display("FAIL single_grant: got %0d grants first ch %0d expected 1 grant ch 2", gnum, glog_ch[0]); end
    compared++;
    if (glog_cyc[0] !== start + 1) begin mismatched++; $display("FAIL single_grant_latency: got cyc %0d expected %0d", glog_cyc[0], start + 1); end
    compared++;
    if (onum !== 4) begin mismatched++; $display("FAIL single_words: got %0d expected 4", onum); end
    compared++;
    if (olog_cyc[0] !== start + 3) begin mismatched++; $display("FAIL single_first_out: got cyc %0d expected %0d", olog_cyc[0], start + 3); end
    for (int i = 1; i < 4; i++) begin
      compared++;
      if (olog_cyc[i] !== olog_cyc[0] + i) begin
        mismatched++; $display("FAIL single_consecutive_w%0d: got cyc %0d expected %0d", i, olog_cyc[i], olog_cyc[0] + i);
      end
    end
  endtask

  task automatic test_fairness();
    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < NCH; c++) add_packet(c, p, c + 1 + p);
    run_drain(200, "fair");
    compared++;
    if (gnum !== 8) begin mismatched++; $display("FAIL fair_grants: got %0d expected 8", gnum); end
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (glog_ch[i] !== exp_order[i]) begin
        mismatched++; $display("FAIL fair_order_%0d: got ch %0d expected ch %0d", i, glog_ch[i], exp_order[i]);
      end
    end
    compared++;
    if (onum !== 24) begin mismatched++; $display("FAIL fair_words: got %0d expected 24", onum); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy_pat = 4'b1001;
    add_packet(1, 5, 6);
    run_drain(100, "bp");
    compared++;
    if (gnum !== 1 || glog_ch[0] !== 1) begin mismatched++; $display("FAIL bp_grant: got %0d grants ch %0d expected 1 grant ch 1", gnum, glog_ch[0]); end
    compared++;
    if (onum !== 6) begin mismatched++; $display("FAIL bp_words: got %0d expected 6", onum); end
  endtask

  task automatic test_late_eligibility();
    int exp_order [3] = '{0, 1, 3};
    do_reset();
    add_packet(0, 1, 5);
    add_packet(1, 1, 3);
    repeat (3) step();
    add_packet(3, 1, 2);
    run_drain(100, "late");
    compared++;
    if (gnum !== 3) begin mismatched++; $display("FAIL late_grants: got %0d expected 3", gnum); end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (glog_ch[i] !== exp_order[i]) begin
        mismatched++; $display("FAIL late_order_%0d: got ch %0d expected ch %0d", i, glog_ch[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int p = 0; p < 3; p++) add_packet(1, p, 1);
    run_drain(60, "b2b");
    compared++;
    if (gnum !== 3) begin mismatched++; $display("FAIL b2b_grants: got %0d expected 3", gnum); end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (glog_ch[i] !== 1) begin mismatched++; $display("FAIL b2b_ch_%0d: got ch %0d expected ch 1", i, glog_ch[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      compared++;
      if (glog_cyc[i] - glog_cyc[i-1] !== 2) begin
        mismatched++; $display("FAIL b2b_gap_%0d: got %0d cycles expected 2", i, glog_cyc[i] - glog_cyc[i-1]);
      end
    end
    compared++;
    if (onum !== 3) begin mismatched++; $display("FAIL b2b_words: got %0d expected 3", onum); end
  endtask

  task automatic test_reset_mid_packet();
    int n = 0;
    int exp_order [2] = '{0, 3};
    do_reset();
    add_packet(1, 7, 5);
    while (onum < 2 && n < 20) begin
      step();
      n++;
    end
    compared++;
    if (onum < 2) begin mismatched++; $display("FAIL rstmid_progress: got %0d words expected 2", onum); end
    rst = 1'b1;
    #1;
    compared++;
    if (out_if.tvalid !== 1'b0) begin mismatched++; $display("FAIL rstmid_tvalid: got %b expected 0", out_if.tvalid); end
    compared++;
    if (grant !== '0) begin mismatched++; $display("FAIL rstmid_grant: got %b expected 0", grant); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    compared++;
    if (src_ready !== '0) begin mismatched++; $display("FAIL rstmid_tready: got %b expected 0", src_ready); end
    do_reset();
    add_packet(3, 8, 2);
    add_packet(0, 8, 2);
    run_drain(60, "rstmid");
    compared++;
    if (gnum !== 2) begin mismatched++; $display("FAIL rstmid_grants: got %0d expected 2", gnum); end
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (glog_ch[i] !== exp_order[i]) begin
        mismatched++; $display("FAIL rstmid_order_%0d: got ch %0d expected ch %0d", i, glog_ch[i], exp_order[i]);
      end
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    $display("test_reset done: compared=%0d mismatched=%0d", compared, mismatched);
    test_single_channel();
    $display("test_single_channel done: compared=%0d mismatched=%0d", compared, mismatched);
    test_fairness();
    $display("test_fairness done: compared=%0d mismatched=%0d", compared, mismatched);
    test_backpressure();
    $display("test_backpressure done: compared=%0d mismatched=%0d", compared, mismatched);
    test_late_eligibility();
    $display("test_late_eligibility done: compared=%0d mismatched=%0d", compared, mismatched);
    test_back_to_back();
    $display("test_back_to_back done: compared=%0d mismatched=%0d", compared, mismatched);
    test_reset_mid_packet();
    $display("test_reset_mid_packet done: compared=%0d mismatched=%0d", compared, mismatched);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
